// File: rtl/nvram_upload_rd_if.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_rd_if
//  Description : HPS ioctl upload bus between hps_io (master) and the
//                NVRAM upload reader (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface nvram_upload_rd_if;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;

   modport master (
      output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
      input  ioctl_din, ioctl_wait
   );

   modport slave (
      input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
      output ioctl_din, ioctl_wait
   );
endinterface
`default_nettype wire

// File: rtl/nvram_upload_rd.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_rd
//  Description : Serves HPS NVRAM upload requests from the 1Kx4 CMOS read
//                port and raises a one-shot save request once CPU writes to
//                CMOS have gone quiet.
//  Revision    : 1.0 - initial release
// ============================================================================
module nvram_upload_rd #(
   parameter int          NV_INDEX     = 4,
   parameter int          NV_SIZE      = 1024,
   parameter int          RD_LAT       = 2,
   parameter logic [23:0] QUIET_CYCLES = 24'd6_000_000
) (
   input  wire              clk_sys,
   input  wire              reset_n,
   nvram_upload_rd_if.slave ioctl,
   output logic [9:0]       nv_addr,
   output logic             nv_rd,
   input  wire  [3:0]       nv_q,
   input  wire              cmos_we,
   output logic             nv_dirty,
   output logic             save_req
);

   localparam logic [2:0]  IDLE     = 3'd0;
   localparam logic [2:0]  ISSUE    = 3'd1;
   localparam logic [2:0]  WAIT     = 3'd2;
   localparam logic [2:0]  CAPTURE  = 3'd3;
   localparam logic [2:0]  FILL     = 3'd4;

   localparam logic [2:0]  LAT_LOAD = 3'(RD_LAT - 1);
   localparam logic [24:0] SIZE_25  = 25'(NV_SIZE);
   localparam logic [7:0]  IDX_8    = 8'(NV_INDEX);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [2:0]  lat_cnt;
   logic [7:0]  byte_out;
   logic [23:0] quiet_cnt;
   logic        save_done;
   logic        sel;
   logic        sel_d;
   logic        sel_rise;
   logic        sel_fall;
   logic        we_seen;
   logic        accept;
   logic        in_range;

   assign sel      = ioctl.ioctl_upload & (ioctl.ioctl_index == IDX_8);
   assign sel_rise = sel & ~sel_d;
   assign sel_fall = sel_d & ~sel;
   assign accept   = (state == IDLE) & ioctl.ioctl_rd & sel;
   // Range is judged on the full address so 1024 and above never alias.
   assign in_range = (ioctl.ioctl_addr < SIZE_25);

   assign ioctl.ioctl_din = byte_out;

   // FSM state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // FSM next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = in_range ? ISSUE : FILL;
         ISSUE:   state_nxt = (RD_LAT == 1) ? CAPTURE : WAIT;
         WAIT:    if (lat_cnt <= 3'd1) state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         FILL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; wait includes the raw request so it rises with ioctl_rd
   always_comb begin
      nv_rd            = (state == ISSUE);
      ioctl.ioctl_wait = (state != IDLE) | (ioctl.ioctl_rd & sel);
   end

   // Read datapath: latched address, latency counter and returned byte
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         nv_addr  <= 10'd0;
         lat_cnt  <= 3'd0;
         byte_out <= 8'h00;
      end else begin
         if (accept)            nv_addr <= ioctl.ioctl_addr[9:0];
         if (state == ISSUE)    lat_cnt <= LAT_LOAD;
         else if (state == WAIT && lat_cnt != 3'd0)
                                lat_cnt <= lat_cnt - 3'd1;
         // Upper nibble floats high on the board, so it reads back as F.
         if (state == CAPTURE)  byte_out <= {4'hF, nv_q};
         else if (state == FILL) byte_out <= 8'hFF;
      end
   end

   // Upload edge tracking: remembers whether CMOS was written during upload
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sel_d   <= 1'b0;
         we_seen <= 1'b0;
      end else begin
         sel_d <= sel;
         if (sel_rise)           we_seen <= cmos_we;
         else if (sel & cmos_we) we_seen <= 1'b1;
      end
   end

   // Dirty flag and quiet counter; a CPU write always wins
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         nv_dirty  <= 1'b0;
         quiet_cnt <= 24'd0;
         save_done <= 1'b0;
      end else if (cmos_we) begin
         nv_dirty  <= 1'b1;
         quiet_cnt <= 24'd0;
         save_done <= 1'b0;
      end else if (sel_fall) begin
         // Writes during the upload keep the image dirty and restart the wait.
         nv_dirty  <= we_seen;
         quiet_cnt <= 24'd0;
         save_done <= 1'b0;
      end else begin
         if (nv_dirty && quiet_cnt < QUIET_CYCLES) quiet_cnt <= quiet_cnt + 24'd1;
         if (save_req) save_done <= 1'b1;
      end
   end

   // One save pulse per quiet period, held off while an upload is selected
   // and dropped if the upload end is about to clear the dirty flag.
   always_comb begin
      save_req = nv_dirty & (quiet_cnt == QUIET_CYCLES) & ~save_done & ~sel
               & ~(sel_fall & ~we_seen & ~cmos_we);
   end

endmodule
`default_nettype wire

// File: tb/tb_nvram_upload_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nvram_upload_rd
//  Description : Directed bench for nvram_upload_rd with a CMOS model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nvram_upload_rd;
   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [9:0] nv_addr;
   logic       nv_rd;
   logic [3:0] nv_q;
   logic       cmos_we;
   logic       nv_dirty;
   logic       save_req;

   logic [3:0] mem [0:1023];
   logic [3:0] pipe1, pipe2;
   int         n_cmp = 0;
   int         n_err = 0;
   int         rd_pulses = 0;

   nvram_upload_rd_if bus ();

   nvram_upload_rd #(
      .NV_INDEX     (4),
      .NV_SIZE      (1024),
      .RD_LAT       (2),
      .QUIET_CYCLES (24'd100)
   ) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .ioctl    (bus),
      .nv_addr  (nv_addr),
      .nv_rd    (nv_rd),
      .nv_q     (nv_q),
      .cmos_we  (cmos_we),
      .nv_dirty (nv_dirty),
      .save_req (save_req)
   );

   always #5 clk_sys = ~clk_sys;

   // CMOS read port model with two cycles of latency
   always @(posedge clk_sys) begin
      pipe1 <= mem[nv_addr];
      pipe2 <= pipe1;
      if (nv_rd) rd_pulses <= rd_pulses + 1;
   end
   assign nv_q = pipe2;

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Request at addr 5 with RD_LAT=2: wait high cycles 0-3, FA in cycle 4
   task automatic req_addr5(input string tag);
      int base;
      base = rd_pulses;
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd5; #1;
      check({tag, "_wait_c0"}, 32'(bus.ioctl_wait), 32'd1);
      tick; bus.ioctl_rd = 1'b0; #1;
      check({tag, "_nvrd_c1"}, 32'(nv_rd), 32'd1);
      check({tag, "_nvaddr_c1"}, 32'(nv_addr), 32'h005);
      check({tag, "_wait_c1"}, 32'(bus.ioctl_wait), 32'd1);
      tick;
      check({tag, "_nvrd_c2"}, 32'(nv_rd), 32'd0);
      check({tag, "_wait_c2"}, 32'(bus.ioctl_wait), 32'd1);
      tick;
      check({tag, "_wait_c3"}, 32'(bus.ioctl_wait), 32'd1);
      tick;
      check({tag, "_wait_c4"}, 32'(bus.ioctl_wait), 32'd0);
      check({tag, "_din_c4"}, 32'(bus.ioctl_din), 32'h0FA);
      check({tag, "_pulses"}, 32'(rd_pulses - base), 32'd1);
   endtask

   initial begin
      int base, k, npulse, pc;
      logic [24:0] oor [0:1];

      for (int i = 0; i < 1024; i++) mem[i] = 4'((i * 7 + 3) & 15);
      mem[5] = 4'hA;
      oor[0] = 25'd1024;
      oor[1] = 25'h1_0000;

      reset_n = 1'b0;
      bus.ioctl_upload = 1'b0; bus.ioctl_index = 8'd0;
      bus.ioctl_rd = 1'b0;     bus.ioctl_addr = 25'd0;
      cmos_we = 1'b0;
      repeat (3) @(posedge clk_sys);
      #2;
      check("rst_din",   32'(bus.ioctl_din),  32'h00);
      check("rst_wait",  32'(bus.ioctl_wait), 32'd0);
      check("rst_addr",  32'(nv_addr),        32'd0);
      check("rst_nvrd",  32'(nv_rd),          32'd0);
      check("rst_dirty", 32'(nv_dirty),       32'd0);
      check("rst_save",  32'(save_req),       32'd0);
      reset_n = 1'b1;
      tick;

      // Single in-range request
      bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd4;
      tick;
      req_addr5("a5");

      // Full image sweep honoring wait
      base = rd_pulses;
      for (int i = 0; i < 1024; i++) begin
         bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'(i);
         tick; bus.ioctl_rd = 1'b0; #1;
         k = 0;
         while (bus.ioctl_wait && k < 20) begin tick; k++; end
         check("sweep_timeout", 32'(k < 20), 32'd1);
         check("sweep_byte", 32'(bus.ioctl_din), 32'({4'hF, mem[i]}));
      end
      check("sweep_pulses", 32'(rd_pulses - base), 32'd1024);

      // Out-of-range requests return FF without touching the RAM
      for (int j = 0; j < 2; j++) begin
         base = rd_pulses;
         bus.ioctl_rd = 1'b1; bus.ioctl_addr = oor[j]; #1;
         check("oor_wait_c0", 32'(bus.ioctl_wait), 32'd1);
         tick; bus.ioctl_rd = 1'b0; #1;
         check("oor_wait_c1", 32'(bus.ioctl_wait), 32'd1);
         check("oor_nvrd_c1", 32'(nv_rd), 32'd0);
         tick;
         check("oor_wait_c2", 32'(bus.ioctl_wait), 32'd0);
         check("oor_din_c2", 32'(bus.ioctl_din), 32'h0FF);
         check("oor_pulses", 32'(rd_pulses - base), 32'd0);
      end
      bus.ioctl_upload = 1'b0;
      tick; tick;

      // Quiet timer: writes at cycles 0 and 50, save expected at 151
      check("q_dirty_pre", 32'(nv_dirty), 32'd0);
      cmos_we = 1'b1; #1;
      tick; cmos_we = 1'b0; #1;
      check("q_dirty_c1", 32'(nv_dirty), 32'd1);
      npulse = 0; pc = 0;
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) tick;
         cmos_we = (c == 50); #1;
         if (save_req) begin npulse++; pc = c; end
      end
      cmos_we = 1'b0;
      check("q_save_count", 32'(npulse), 32'd1);
      check("q_save_cycle", 32'(pc), 32'd151);

      // Upload with a write in the middle keeps dirty and restarts the timer
      bus.ioctl_upload = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cmos_we = (c == 4);
         tick;
      end
      cmos_we = 1'b0;
      check("uw_save_sel", 32'(save_req), 32'd0);
      bus.ioctl_upload = 1'b0; #1;
      tick;
      check("uw_dirty", 32'(nv_dirty), 32'd1);
      npulse = 0; pc = 0;
      for (int c = 1; c <= 150; c++) begin
         if (c > 1) tick;
         if (save_req) begin npulse++; pc = c; end
      end
      check("uw_save_count", 32'(npulse), 32'd1);
      check("uw_save_cycle", 32'(pc), 32'd101);

      // Upload without a write clears dirty at upload end
      bus.ioctl_upload = 1'b1;
      repeat (5) tick;
      bus.ioctl_upload = 1'b0; #1;
      check("un_dirty_fall", 32'(nv_dirty), 32'd1);
      tick;
      check("un_dirty_after", 32'(nv_dirty), 32'd0);
      npulse = 0;
      for (int c = 0; c < 120; c++) begin
         tick;
         if (save_req) npulse++;
      end
      check("un_save_count", 32'(npulse), 32'd0);

      // Asynchronous reset in the middle of a read
      bus.ioctl_upload = 1'b1;
      cmos_we = 1'b1; tick; cmos_we = 1'b0; #1;
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd5; #1;
      tick; bus.ioctl_rd = 1'b0; #1;
      tick;
      check("ar_wait_pre", 32'(bus.ioctl_wait), 32'd1);
      check("ar_dirty_pre", 32'(nv_dirty), 32'd1);
      #2 reset_n = 1'b0; #1;
      check("ar_din",   32'(bus.ioctl_din),  32'h00);
      check("ar_wait",  32'(bus.ioctl_wait), 32'd0);
      check("ar_addr",  32'(nv_addr),        32'd0);
      check("ar_nvrd",  32'(nv_rd),          32'd0);
      check("ar_dirty", 32'(nv_dirty),       32'd0);
      check("ar_save",  32'(save_req),       32'd0);
      #2 reset_n = 1'b1;
      tick;
      req_addr5("ar_a5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nvram_upload_rd.md
# nvram_upload_rd

Reader side of the NVRAM path: services HPS upload requests (ioctl index 4) by fetching bytes from the 1K×4 CMOS RAM read port and returning them on `ioctl_din`, stretching each request with `ioctl_wait`. It also tracks CMOS writes from the game CPU and raises a one-shot save request after writes go quiet. It sits beside `williams_ram`, between `hps_io` and the CMOS read port, and mirrors the existing download/write path.

## Interface
- `NV_INDEX`, 4: ioctl index that selects NVRAM.
- `NV_SIZE`, 1024: CMOS depth in bytes; must be a power of two, at most 1024.
- `RD_LAT`, 2: CMOS read latency in cycles from `nv_rd` to valid `nv_q`; range 1–7.
- `QUIET_CYCLES`, 24'd6_000_000: cycles without a CMOS write before a save request is issued.

Ports:
- `clk_sys` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: upload in progress.
- `ioctl_index` in 8: selected image index.
- `ioctl_rd` in 1: one-cycle byte request strobe.
- `ioctl_addr` in 25: requested byte address; valid when `ioctl_rd` is high.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: request not yet served.
- `nv_addr` out 10: CMOS read address.
- `nv_rd` out 1: CMOS read enable, one-cycle pulse.
- `nv_q` in 4: CMOS read data.
- `cmos_we` in 1: CPU write to CMOS, one pulse per write.
- `nv_dirty` out 1: CMOS has changed since the last completed upload.
- `save_req` out 1: one-cycle pulse asking the HPS to save.

## Operation
- A request is accepted when `sel = ioctl_upload & (ioctl_index == NV_INDEX)` and `ioctl_rd` are high together in the IDLE state.
- `ioctl_wait = (state != IDLE) | (ioctl_rd & sel)`. It is combinational, so there is no gap before the first wait cycle.
- States and transitions:
  - IDLE: accept a request and latch the address. If `addr < NV_SIZE`, go to ISSUE. Otherwise go to FILL.
  - ISSUE: `nv_rd = 1` and `nv_addr = addr[9:0]`. Load the latency counter with `RD_LAT-1`, then go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, go to CAPTURE.
  - CAPTURE: register `ioctl_din <= {4'hF, nv_q}`, matching the board's floating upper nibble. Go to IDLE.
  - FILL: register `ioctl_din <= 8'hFF` with no RAM access. Go to IDLE.
- `ioctl_rd` pulses received outside IDLE are ignored; the HPS never issues them while `ioctl_wait` is high.
- If `sel` drops while not in IDLE, the current access finishes normally. No new requests are accepted after that.
- Dirty and save tracking:
  - `cmos_we` sets `nv_dirty` and clears the 24-bit quiet counter.
  - While `nv_dirty` is set and the counter is below `QUIET_CYCLES`, the counter increments.
  - When the counter reaches `QUIET_CYCLES`, `save_req` pulses for one cycle and the counter holds. Only one pulse is issued per quiet period.
  - On the falling edge of `sel`, which marks upload end, `nv_dirty` clears. It does not clear if any `cmos_we` occurred between the rising and falling edges of `sel`, including the falling-edge cycle itself. In that case `nv_dirty` stays set and the quiet counter restarts from 0.
  - `save_req` is suppressed while `sel` is high. If the threshold is hit during that time, the pulse is deferred to the first cycle after `sel` falls, and is only issued if `nv_dirty` is still set.

## Timing
- Reset values: `ioctl_din = 8'h00`, `ioctl_wait = 0` (no request present), `nv_addr = 0`, `nv_rd = 0`, `nv_dirty = 0`, `save_req = 0`. The state is IDLE and all counters are 0.
- In-range latency, with the request at cycle 0:
  - Cycle 1: ISSUE (`nv_rd` high).
  - Cycles 2..RD_LAT: WAIT.
  - Cycle RD_LAT+1: CAPTURE. `nv_q` is sampled here.
  - Cycle RD_LAT+2: `ioctl_din` is valid and `ioctl_wait` is low.
  - With `RD_LAT = 2`: wait is high in cycles 0–3, data is valid in cycle 4, and the next request is accepted in cycle 4.
  - With `RD_LAT = 1`, WAIT is skipped.
- Out-of-range latency: wait is high in cycles 0–1, and `8'hFF` is valid in cycle 2.
- Address wrap: only `addr[9:0]` drives the RAM. Range is decided on the full 25-bit address, so address 1024 returns FF and never aliases to 0.
- An asynchronous reset mid-access returns to IDLE immediately. `ioctl_wait` then follows only the combinational request term.
- `cmos_we` takes priority over the quiet-counter increment and over the upload-end clear when they occur in the same cycle.

## Test plan
- Preload CMOS[0x005] = 4'hA, `RD_LAT = 2`. Upload request at addr 5 → `nv_rd` pulses in cycle 1 with `nv_addr = 0x005`; `ioctl_wait` is high in cycles 0–3; `ioctl_din = 8'hFA` in cycle 4.
- Upload back-to-back requests at addresses 0..1023 with the HPS honoring wait → 1024 bytes, each equal to `{F, CMOS[i]}`, and no extra `nv_rd` pulses.
- Request at addr 1024 and at addr 0x1_0000 → `ioctl_din = 8'hFF` two cycles after the request, with no `nv_rd` pulse.
- Set `QUIET_CYCLES = 100`. Pulse `cmos_we` at cycles 0 and 50 → `nv_dirty` is high from cycle 1; exactly one `save_req` pulse occurs at cycle 151 ±1; none afterwards.
- Start an upload, pulse `cmos_we` mid-upload, then end the upload → `nv_dirty` stays 1 and `save_req` fires `QUIET_CYCLES` after the upload ends. Repeat the upload with no write → `nv_dirty` clears on the falling edge of `sel`.
- Assert `reset_n = 0` during WAIT → all outputs take their reset values within the same cycle. After release, a new request at addr 5 completes with the normal latency.
